rsa_core_div: RTL and testbench

- Sequential restoring shift-subtract divider/modulo unit for the RSA datapath; the inverse of the shift-add multiplier.
- Takes a 2*DATA_WIDTH dividend (a multiplier product) and a DATA_WIDTH divisor (modulus).
- Returns quotient and remainder after a start/done handshake, one quotient bit per clock.
- Used for modular reduction after each multiply in modular exponentiation.

---
 rtl/rsa_core_div_if.sv | 25 ++
 rtl/rsa_core_div.sv | 128 ++++++++++++
 tb/tb_rsa_core_div.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/rsa_core_div_if.sv
// Operand/result bundle for the rsa_core_div divider.
//   master : drives div_start, div_n (dividend), div_d (divisor);
//            receives div_done, div_err, div_q (quotient), div_r (remainder).
//   slave  : the divider side of the same signals.
interface rsa_core_div_if #(
  parameter int DATA_WIDTH = 8
);
  logic                    div_start;
  logic [2*DATA_WIDTH-1:0] div_n;
  logic [DATA_WIDTH-1:0]   div_d;
  logic                    div_done;
  logic                    div_err;
  logic [2*DATA_WIDTH-1:0] div_q;
  logic [DATA_WIDTH-1:0]   div_r;

  modport master (
    output div_start, div_n, div_d,
    input  div_done, div_err, div_q, div_r
  );

  modport slave (
    input  div_start, div_n, div_d,
    output div_done, div_err, div_q, div_r
  );
endinterface

// File: rtl/rsa_core_div.sv
// rsa_core_div: sequential restoring shift-subtract divider / modulo unit.
// Divides a 2*DATA_WIDTH dividend by a DATA_WIDTH divisor, one quotient bit
// per clock, and returns quotient and remainder with a one-cycle done pulse.
//
// Ports:
//   div_clk  block clock (active edge chosen by CLK_EDGE)
//   div_rst  synchronous active-high reset
//   bus      rsa_core_div_if.slave: div_start/div_n/div_d in,
//            div_done/div_err/div_q/div_r out (all registered)
//
// Parameters: DATA_WIDTH (2..32), CLK_EDGE (1 rising, 0 falling),
//             START (div_start level that requests an operation).
//
// Build option: define RSA_CORE_DIV_FASTPATH_EN to finish immediately when
// the dividend is already smaller than a non-zero divisor.
module rsa_core_div #(
  parameter int DATA_WIDTH = 8,
  parameter bit CLK_EDGE   = 1'b1,
  parameter bit START      = 1'b1
) (
  input  logic            div_clk,
  input  logic            div_rst,
  rsa_core_div_if.slave   bus
);
  localparam int N     = 2 * DATA_WIDTH;
  localparam int DW    = DATA_WIDTH;
  localparam int CNT_W = (N <= 2)  ? 1 :
                         (N <= 4)  ? 2 :
                         (N <= 8)  ? 3 :
                         (N <= 16) ? 4 :
                         (N <= 32) ? 5 : 6;

  typedef enum logic [1:0] {IDLE, CHECK, ITER, DONE} state_t;

  logic clk_i;
  assign clk_i = CLK_EDGE ? div_clk : ~div_clk;

  state_t           state;
  logic [N-1:0]     n_reg;
  logic [DW-1:0]    d_reg;
  logic [DW:0]      r_reg;
  logic [CNT_W-1:0] cnt;
  logic             done_ff;
  logic             err_ff;
  logic [N-1:0]     q_ff;
  logic [DW-1:0]    r_ff;

  // Trial subtract one bit wider than the partial remainder so the MSB is
  // the borrow: borrow clear means t >= d and the quotient bit is 1.
  logic [DW+1:0] t;
  logic [DW+1:0] sub;
  logic          qbit;
  logic          fast_hit;

  always_comb begin
    t    = {r_reg, n_reg[N-1]};
    sub  = t - {2'b00, d_reg};
    qbit = ~sub[DW+1];
  end

`ifdef RSA_CORE_DIV_FASTPATH_EN
  assign fast_hit = (n_reg < {{DW{1'b0}}, d_reg});
`else
  assign fast_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (div_rst) begin
      state   <= IDLE;
      n_reg   <= '0;
      d_reg   <= '0;
      r_reg   <= '0;
      cnt     <= '0;
      done_ff <= 1'b0;
      err_ff  <= 1'b0;
      q_ff    <= '0;
      r_ff    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_ff <= 1'b0;
          if (bus.div_start == START) begin
            n_reg  <= bus.div_n;
            d_reg  <= bus.div_d;
            r_reg  <= '0;
            cnt    <= '0;
            err_ff <= 1'b0;
            state  <= CHECK;
          end
        end
        CHECK: begin
          // Early exits preload n_reg/r_reg so DONE publishes them unchanged:
          // all-ones quotient on divide-by-zero, zero quotient on fast path.
          if (d_reg == '0) begin
            err_ff <= 1'b1;
            n_reg  <= '1;
            r_reg  <= {1'b0, n_reg[DW-1:0]};
            state  <= DONE;
          end else if (fast_hit) begin
            n_reg  <= '0;
            r_reg  <= {1'b0, n_reg[DW-1:0]};
            state  <= DONE;
          end else begin
            state  <= ITER;
          end
        end
        ITER: begin
          r_reg <= qbit ? sub[DW:0] : t[DW:0];
          n_reg <= {n_reg[N-2:0], qbit};
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(N - 1)) state <= DONE;
        end
        DONE: begin
          q_ff    <= n_reg;
          r_ff    <= r_reg[DW-1:0];
          done_ff <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.div_done = done_ff;
  assign bus.div_err  = err_ff;
  assign bus.div_q    = q_ff;
  assign bus.div_r    = r_ff;
endmodule

// File: tb/tb_rsa_core_div.sv
module tb_rsa_core_div;
  localparam int DW = 8;
`ifdef RSA_CORE_DIV_FASTPATH_EN
  localparam int SMALL_LAT = 2;
`else
  localparam int SMALL_LAT = 18;
`endif

  logic div_clk = 1'b0;
  logic div_rst;
  rsa_core_div_if #(.DATA_WIDTH(DW)) bus ();

  rsa_core_div #(.DATA_WIDTH(DW), .CLK_EDGE(1'b1), .START(1'b1)) dut (
    .div_clk (div_clk),
    .div_rst (div_rst),
    .bus     (bus.slave)
  );

  always #5 div_clk = ~div_clk;

  int    n_cmp = 0;
  int    n_err = 0;
  longint cyc  = 0;
  always @(posedge div_clk) cyc++;

  // Issue one start pulse; lat = edges from start sample to done (-1 timeout),
  // plen = 1 if done dropped on the following edge, 2 if it stayed high.
  task automatic run_op(input logic [15:0] n, input logic [7:0] d,
                        output int lat, output int plen);
    @(negedge div_clk);
    bus.div_n = n; bus.div_d = d; bus.div_start = 1'b1;
    @(posedge div_clk); #1;
    bus.div_start = 1'b0;
    lat = -1; plen = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge div_clk); #1;
      if (bus.div_done) begin lat = k; break; end
    end
    if (lat > 0) begin
      plen = 1;
      @(posedge div_clk); #1;
      if (bus.div_done) plen = 2;
    end
  endtask

  task automatic test_reset();
    div_rst = 1'b1; bus.div_start = 1'b0; bus.div_n = '0; bus.div_d = '0;
    repeat (2) @(posedge div_clk);
    #1;
    n_cmp++; if (bus.div_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.div_done); end
    n_cmp++; if (bus.div_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", bus.div_err); end
    n_cmp++; if (bus.div_q !== 16'd0) begin n_err++; $display("FAIL reset_q: got %0d want 0", bus.div_q); end
    n_cmp++; if (bus.div_r !== 8'd0) begin n_err++; $display("FAIL reset_r: got %0d want 0", bus.div_r); end
    @(negedge div_clk); div_rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, plen;
    run_op(16'd1000, 8'd7, lat, plen);
    n_cmp++; if (lat !== 18) begin n_err++; $display("FAIL basic_latency: got %0d want 18", lat); end
    n_cmp++; if (plen !== 1) begin n_err++; $display("FAIL basic_pulse_len: got %0d want 1", plen); end
    n_cmp++; if (bus.div_q !== 16'd142) begin n_err++; $display("FAIL basic_q: got %0d want 142", bus.div_q); end
    n_cmp++; if (bus.div_r !== 8'd6) begin n_err++; $display("FAIL basic_r: got %0d want 6", bus.div_r); end
    n_cmp++; if (bus.div_err !== 1'b0) begin n_err++; $display("FAIL basic_err: got %b want 0", bus.div_err); end
  endtask

  task automatic test_extremes();
    int lat, plen;
    run_op(16'd65535, 8'd255, lat, plen);
    n_cmp++; if (bus.div_q !== 16'd257) begin n_err++; $display("FAIL max_by_255_q: got %0d want 257", bus.div_q); end
    n_cmp++; if (bus.div_r !== 8'd0) begin n_err++; $display("FAIL max_by_255_r: got %0d want 0", bus.div_r); end
    run_op(16'd65535, 8'd1, lat, plen);
    n_cmp++; if (bus.div_q !== 16'd65535) begin n_err++; $display("FAIL max_by_1_q: got %0d want 65535", bus.div_q); end
    n_cmp++; if (bus.div_r !== 8'd0) begin n_err++; $display("FAIL max_by_1_r: got %0d want 0", bus.div_r); end
    n_cmp++; if (lat !== 18) begin n_err++; $display("FAIL max_by_1_latency: got %0d want 18", lat); end
  endtask

  task automatic test_div_zero();
    int lat, plen;
    run_op(16'd1234, 8'd0, lat, plen);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL dz_latency: got %0d want 2", lat); end
    n_cmp++; if (plen !== 1) begin n_err++; $display("FAIL dz_pulse_len: got %0d want 1", plen); end
    n_cmp++; if (bus.div_err !== 1'b1) begin n_err++; $display("FAIL dz_err: got %b want 1", bus.div_err); end
    n_cmp++; if (bus.div_q !== 16'hFFFF) begin n_err++; $display("FAIL dz_q: got %h want ffff", bus.div_q); end
    n_cmp++; if (bus.div_r !== 8'hD2) begin n_err++; $display("FAIL dz_r: got %h want d2", bus.div_r); end
    run_op(16'd1000, 8'd7, lat, plen);
    n_cmp++; if (bus.div_err !== 1'b0) begin n_err++; $display("FAIL dz_err_clear: got %b want 0", bus.div_err); end
    n_cmp++; if (bus.div_q !== 16'd142) begin n_err++; $display("FAIL dz_after_q: got %0d want 142", bus.div_q); end
  endtask

  task automatic test_small();
    int lat, plen;
    run_op(16'd5, 8'd9, lat, plen);
    n_cmp++; if (lat !== SMALL_LAT) begin n_err++; $display("FAIL small_latency: got %0d want %0d", lat, SMALL_LAT); end
    n_cmp++; if (bus.div_q !== 16'd0) begin n_err++; $display("FAIL small_q: got %0d want 0", bus.div_q); end
    n_cmp++; if (bus.div_r !== 8'd5) begin n_err++; $display("FAIL small_r: got %0d want 5", bus.div_r); end
  endtask

  task automatic test_reset_mid();
    int lat, plen;
    bit seen;
    run_op(16'd1000, 8'd7, lat, plen);  // leave non-zero outputs behind
    @(negedge div_clk);
    bus.div_n = 16'd1000; bus.div_d = 8'd7; bus.div_start = 1'b1;
    @(posedge div_clk); #1;             // edge 0
    bus.div_start = 1'b0;
    repeat (7) @(posedge div_clk);      // edges 1..7
    @(negedge div_clk); div_rst = 1'b1;
    @(posedge div_clk); #1;             // edge 8
    n_cmp++; if (bus.div_q !== 16'd0) begin n_err++; $display("FAIL midrst_q: got %0d want 0", bus.div_q); end
    n_cmp++; if (bus.div_r !== 8'd0) begin n_err++; $display("FAIL midrst_r: got %0d want 0", bus.div_r); end
    n_cmp++; if (bus.div_err !== 1'b0) begin n_err++; $display("FAIL midrst_err: got %b want 0", bus.div_err); end
    n_cmp++; if (bus.div_done !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b want 0", bus.div_done); end
    @(negedge div_clk); div_rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge div_clk); #1;
      if (bus.div_done) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL midrst_no_done: got %b want 0", seen); end
    run_op(16'd65535, 8'd255, lat, plen);
    n_cmp++; if (lat !== 18) begin n_err++; $display("FAIL midrst_next_latency: got %0d want 18", lat); end
    n_cmp++; if (bus.div_q !== 16'd257) begin n_err++; $display("FAIL midrst_next_q: got %0d want 257", bus.div_q); end
  endtask

  task automatic test_no_resample();
    int lat;
    @(negedge div_clk);
    bus.div_n = 16'd1000; bus.div_d = 8'd7; bus.div_start = 1'b1;
    @(posedge div_clk); #1;
    bus.div_start = 1'b0; bus.div_n = 16'd50000; bus.div_d = 8'd3;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge div_clk); #1;
      if (k == 5) bus.div_start = 1'b1;
      if (k == 6) bus.div_start = 1'b0;
      if (bus.div_done) begin lat = k; break; end
    end
    bus.div_start = 1'b0;
    n_cmp++; if (lat !== 18) begin n_err++; $display("FAIL busy_latency: got %0d want 18", lat); end
    n_cmp++; if (bus.div_q !== 16'd142) begin n_err++; $display("FAIL busy_q: got %0d want 142", bus.div_q); end
    n_cmp++; if (bus.div_r !== 8'd6) begin n_err++; $display("FAIL busy_r: got %0d want 6", bus.div_r); end
    repeat (3) @(posedge div_clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] cn;
    logic [7:0]  cd;
    longint      last;
    bit          got;
    @(negedge div_clk);
    cd = 8'($urandom_range(255, 1));
    cn = 16'($urandom_range(65535, int'(cd)));
    bus.div_n = cn; bus.div_d = cd; bus.div_start = 1'b1;
    last = -1;
    for (int i = 0; i < 2000; i++) begin
      got = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(posedge div_clk); #1;
        if (bus.div_done) begin got = 1'b1; break; end
      end
      n_cmp++;
      if (!got) begin n_err++; $display("FAIL b2b_timeout: op %0d got no done want done", i); break; end
      n_cmp++; if (bus.div_q !== cn / 16'(cd)) begin n_err++; $display("FAIL b2b_q: op %0d n=%0d d=%0d got %0d want %0d", i, cn, cd, bus.div_q, cn / 16'(cd)); end
      n_cmp++; if (bus.div_r !== 8'(cn % 16'(cd))) begin n_err++; $display("FAIL b2b_r: op %0d n=%0d d=%0d got %0d want %0d", i, cn, cd, bus.div_r, cn % 16'(cd)); end
      if (last >= 0) begin
        n_cmp++; if (cyc - last != 19) begin n_err++; $display("FAIL b2b_spacing: op %0d got %0d want 19", i, cyc - last); end
      end
      last = cyc;
      cd = 8'($urandom_range(255, 1));
      cn = 16'($urandom_range(65535, int'(cd)));
      bus.div_n = cn; bus.div_d = cd;
      if (i == 1999) bus.div_start = 1'b0;
    end
    bus.div_start = 1'b0;
    repeat (25) @(posedge div_clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_div_zero();
    test_small();
    test_reset_mid();
    test_no_resample();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
